// File: rtl/ppgen_141088_if.sv
// rtl/ppgen_141088_if.sv - operand input and partial-product output handshake bundle for ppgen_141088.
interface ppgen_141088_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pp0;
  logic [3:0] pp1;
  logic [3:0] pp2;
  logic [3:0] pp3;
  logic [7:0] cnt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp0, pp1, pp2, pp3, cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp0, pp1, pp2, pp3, cnt
  );
endinterface

// File: rtl/ppgen_141088.sv
// rtl/ppgen_141088.sv - registered Baugh-Wooley 4x4 signed partial-product generator.
// Optional one-entry skid register behind the output register: define PPGEN_SKID_EN.
module ppgen_141088 (
  input  logic           clk,
  input  logic           rst,
  ppgen_141088_if.slave  bus
);

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_pp_q, out_pp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pp_new;
  logic        in_xfer, out_xfer;

`ifdef PPGEN_SKID_EN
  logic        skid_full_q, skid_full_d;
  logic [15:0] skid_pp_q, skid_pp_d;
  assign bus.in_ready = !skid_full_q;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  // Rows 0..2 invert their sign-column bit; row 3 inverts its magnitude bits instead.
  always_comb begin
    pp_new = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pp_new[4*i+j] = bus.a[j] & bus.b[i];
      end
      pp_new[4*i+3] = ~(bus.a[3] & bus.b[i]);
    end
    for (int j = 0; j < 3; j++) begin
      pp_new[12+j] = ~(bus.a[j] & bus.b[3]);
    end
    pp_new[15] = bus.a[3] & bus.b[3];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pp_d    = out_pp_q;
    cnt_d       = out_xfer ? cnt_q + 8'd1 : cnt_q;
`ifdef PPGEN_SKID_EN
    skid_full_d = skid_full_q;
    skid_pp_d   = skid_pp_q;
    if (out_xfer || !out_valid_q) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_pp_d    = skid_pp_q;
        if (in_xfer) begin
          skid_pp_d = pp_new;
        end else begin
          skid_full_d = 1'b0;
        end
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_pp_d    = pp_new;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Output is stalled: park the new products behind it.
      skid_full_d = 1'b1;
      skid_pp_d   = pp_new;
    end
`else
    if (out_xfer || !out_valid_q) begin
      if (in_xfer) begin
        out_valid_d = 1'b1;
        out_pp_d    = pp_new;
      end else begin
        out_valid_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pp_q    <= '0;
      cnt_q       <= '0;
`ifdef PPGEN_SKID_EN
      skid_full_q <= 1'b0;
      skid_pp_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_pp_q    <= out_pp_d;
      cnt_q       <= cnt_d;
`ifdef PPGEN_SKID_EN
      skid_full_q <= skid_full_d;
      skid_pp_q   <= skid_pp_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pp0       = out_pp_q[3:0];
  assign bus.pp1       = out_pp_q[7:4];
  assign bus.pp2       = out_pp_q[11:8];
  assign bus.pp3       = out_pp_q[15:12];
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_ppgen_141088.sv
// tb/tb_ppgen_141088.sv - self-checking bench for ppgen_141088 (honours PPGEN_SKID_EN).
module tb_ppgen_141088;

`ifdef PPGEN_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  ppgen_141088_if bus ();

  ppgen_141088 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  txn_t       q[$];
  logic [7:0] exp_cnt;
  bit         last_acc;
  int         checks;
  int         errors;

  // Expected rows straight from the bit rules, packed {pp3,pp2,pp1,pp0}.
  function automatic logic [15:0] exp_pp(input logic [3:0] a, input logic [3:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if ((i == 3) != (j == 3)) r[4*i+j] = ~(a[j] & b[i]);
        else                      r[4*i+j] = a[j] & b[i];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    int sa, sb;
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    return 8'((sa * sb) & 255);
  endfunction

  function automatic logic [7:0] dut_sum();
    int s;
    s = int'(bus.pp0) + 2 * int'(bus.pp1) + 4 * int'(bus.pp2) + 8 * int'(bus.pp3) + 144;
    return 8'(s % 256);
  endfunction

  function automatic logic [15:0] dut_pps();
    return {bus.pp3, bus.pp2, bus.pp1, bus.pp0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit er, acc, oxf;
    txn_t t;
    @(negedge clk);
`ifdef PPGEN_SKID_EN
    er = (q.size() < CAP);
`else
    er = (q.size() == 0) || bus.out_ready;
`endif
    chk("in_ready", 16'(bus.in_ready), 16'(er));
    chk("out_valid", 16'(bus.out_valid), 16'(q.size() > 0));
    if (q.size() > 0) begin
      chk("pp_rows", dut_pps(), exp_pp(q[0].a, q[0].b));
      chk("identity", 16'(dut_sum()), 16'(prod(q[0].a, q[0].b)));
    end
    chk("cnt", 16'(bus.cnt), 16'(exp_cnt));
    acc = bus.in_valid && er;
    oxf = (q.size() > 0) && bus.out_ready;
    t.a = bus.a;
    t.b = bus.b;
    @(posedge clk);
    #1;
    if (oxf) begin
      void'(q.pop_front());
      exp_cnt = exp_cnt + 8'd1;
    end
    if (acc) q.push_back(t);
    last_acc = acc;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    exp_cnt = '0;
    last_acc = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_pps", dut_pps(), 16'h0000);
    chk("rst_cnt", 16'(bus.cnt), 16'd0);

    // Directed vectors from the worked examples.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 4'b0101; bus.b = 4'b0101;
    cycle();
    chk("tp_5x5", dut_pps(), 16'h7D8D);
    chk("tp_5x5_sum", 16'(dut_sum()), 16'h0019);
    bus.a = 4'b1111; bus.b = 4'b1111;
    cycle();
    chk("tp_cnt1", 16'(bus.cnt), 16'd1);
    chk("tp_FxF", dut_pps(), 16'h8777);
    bus.a = 4'b1000; bus.b = 4'b0011;
    cycle();
    chk("tp_8x3", dut_pps(), 16'h7800);
    chk("tp_8x3_sum", 16'(dut_sum()), 16'h00E8);
    bus.in_valid = 1'b0;
    cycle();
    chk("tp_cnt3", 16'(bus.cnt), 16'd3);

    // Stall with three back-to-back offers.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 4'($urandom); bus.b = 4'($urandom);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n += int'(last_acc);
      if (last_acc) begin
        bus.a = 4'($urandom); bus.b = 4'($urandom);
      end
    end
    chk("stall_accepted", 16'(n), 16'(CAP));
    chk("stall_in_ready", 16'(bus.in_ready), 16'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("stall_drained", 16'(bus.out_valid), 16'd0);

    // Counter wrap after 256 output transfers.
    rst = 1'b1;
    q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.a = 4'b0101; bus.b = 4'b0101;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (256) cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("cnt_wrap", 16'(bus.cnt), 16'd0);

    // Randomized traffic; the source holds a/b until accepted.
    repeat (400) begin
      if (!bus.in_valid || last_acc) begin
        bus.in_valid = 1'($urandom);
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("rand_drained", 16'(q.size()), 16'd0);

    // Asynchronous reset while a transaction is stalled.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 4'b0111; bus.b = 4'b0110;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("arst_pps", dut_pps(), 16'h0000);
    chk("arst_cnt", 16'(bus.cnt), 16'd0);
    q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("arst_in_ready", 16'(bus.in_ready), 16'd1);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
